// File: rtl/uart_tx_fifo_pkg.sv
// Shared UART definitions: parity-mode codes, transmitter FSM encoding and the parity helper.
// The receive block is expected to reuse the same codes.
package uart_tx_fifo_pkg;

  localparam logic [1:0] PAR_NONE  = 2'b00;
  localparam logic [1:0] PAR_EVEN  = 2'b01;
  localparam logic [1:0] PAR_ODD   = 2'b10;
  localparam logic [1:0] PAR_SPACE = 2'b11;

  localparam int MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Narrower words are zero-extended by the caller, which leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                      input logic [1:0]                mode);
    logic p;
    case (mode)
      PAR_EVEN:  p = ^data;
      PAR_ODD:   p = ~^data;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Synchronous FIFO with level output; pointers carry an extra MSB so full and empty are
// distinguished without a separate counter.
module uart_tx_fifo_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q;
  logic [AW:0]      rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign level_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage array; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

  // Read/write pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter with input FIFO and internal baud divider. Each frame latches its data and
// line configuration when the word is popped, so mid-frame input changes affect only later frames.
module uart_tx_fifo
  import uart_tx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DIV_WIDTH-1:0]          i_divisor,
  input  logic [1:0]                    i_parity_mode,
  input  logic                          i_two_stop,
  input  logic                          i_valid,
  input  logic [DATA_WIDTH-1:0]         i_data,
  output logic                          o_ready,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          serial_out
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]        LAST_BIT = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0]        CNT_ONE  = CW'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ONE  = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO = {DIV_WIDTH{1'b0}};

  tx_state_e             state_q, state_d;
  logic [DIV_WIDTH-1:0]  timer_q, timer_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [1:0]            par_mode_q, par_mode_d;
  logic                  par_bit_q, par_bit_d;
  logic                  two_stop_q, two_stop_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic                  serial_q, serial_d;

  logic                      fifo_pop;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [DATA_WIDTH-1:0]     fifo_rdata;
  logic [LW-1:0]             fifo_level;
  logic [DIV_WIDTH-1:0]      div_eff;
  logic [MAX_DATA_WIDTH-1:0] par_data;
  logic                      bit_end;
  logic                      load_frame;

  uart_tx_fifo_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (i_valid),
    .wdata_i (i_data),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign div_eff      = (i_divisor == DIV_ZERO) ? DIV_ONE : i_divisor;
  assign bit_end      = (timer_q == DIV_ZERO);
  assign o_ready      = !fifo_full;
  assign o_busy       = (state_q != ST_IDLE) || (fifo_level != {LW{1'b0}});
  assign o_fifo_level = fifo_level;
  assign serial_out   = serial_q;

  // Zero-extend the head word for the shared parity helper.
  always_comb begin
    par_data = {MAX_DATA_WIDTH{1'b0}};
    par_data[DATA_WIDTH-1:0] = fifo_rdata;
  end

  // Frame state register; serial_q resets high so an aborted frame never leaves the line low.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      timer_q    <= DIV_ZERO;
      div_q      <= DIV_ONE;
      bit_cnt_q  <= {CW{1'b0}};
      shift_q    <= {DATA_WIDTH{1'b0}};
      par_mode_q <= PAR_NONE;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      stop_cnt_q <= 1'b0;
      serial_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      div_q      <= div_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_mode_q <= par_mode_d;
      par_bit_q  <= par_bit_d;
      two_stop_q <= two_stop_d;
      stop_cnt_q <= stop_cnt_d;
      serial_q   <= serial_d;
    end
  end

  // Next-state logic: every bit entry reloads the timer with divisor-1.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    div_d      = div_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_mode_d = par_mode_q;
    par_bit_d  = par_bit_q;
    two_stop_d = two_stop_q;
    stop_cnt_d = stop_cnt_q;
    serial_d   = serial_q;
    fifo_pop   = 1'b0;
    load_frame = 1'b0;

    case (state_q)
      ST_IDLE: begin
        serial_d = 1'b1;
        if (!fifo_empty) begin
          load_frame = 1'b1;
        end else begin
          load_frame = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          serial_d  = shift_q[0];
          bit_cnt_d = {CW{1'b0}};
          timer_d   = div_q - DIV_ONE;
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          timer_d = div_q - DIV_ONE;
          if (bit_cnt_q == LAST_BIT) begin
            if (par_mode_q != PAR_NONE) begin
              state_d  = ST_PARITY;
              serial_d = par_bit_q;
            end else begin
              state_d    = ST_STOP;
              serial_d   = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_ONE;
            shift_d   = shift_q >> 1;
            serial_d  = shift_q[1];
          end
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d    = ST_STOP;
          serial_d   = 1'b1;
          stop_cnt_d = 1'b0;
          timer_d    = div_q - DIV_ONE;
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (two_stop_q && !stop_cnt_q) begin
            stop_cnt_d = 1'b1;
            timer_d    = div_q - DIV_ONE;
          end else if (!fifo_empty) begin
            load_frame = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            serial_d = 1'b1;
          end
        end else begin
          timer_d = timer_q - DIV_ONE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        serial_d = 1'b1;
      end
    endcase

    // Pop the head word and latch the whole frame configuration in one step.
    if (load_frame) begin
      fifo_pop   = 1'b1;
      shift_d    = fifo_rdata;
      div_d      = div_eff;
      timer_d    = div_eff - DIV_ONE;
      par_mode_d = i_parity_mode;
      par_bit_d  = parity_bit(par_data, i_parity_mode);
      two_stop_d = i_two_stop;
      stop_cnt_d = 1'b0;
      serial_d   = 1'b0;
      state_d    = ST_START;
    end else begin
      fifo_pop = 1'b0;
    end
  end

endmodule
